// File: rtl/seq_buf.sv
// seq_buf: fixed-depth FIFO buffering a free-running sequence stream with sticky overflow.
// Optional SEQ_BUF_DROP_CNT_EN adds an 8-bit saturating dropped-word counter (drop_cnt).
module seq_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
`ifdef SEQ_BUF_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  input  logic                       ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Status flags come only from the registered count, so no comb path from in_valid/out_ready.
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // A full buffer still accepts a word when the head leaves in the same cycle.
  always_comb begin
    pop  = out_valid & out_ready;
    push = in_valid & (~full | pop);
    drop = in_valid & full & ~pop;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr keeps overflow set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

`ifdef SEQ_BUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (ovf_clr)
      drop_cnt <= '0;
    else if (drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule
